gen_chk_trafico: RTL and testbench
==================================

Name: gen_chk_trafico

Overview:
- Synthesizable, parametrised traffic generator and checker for the N-channel FIFO/arbiter switch.
- Generator side pushes tagged words into the N input FIFOs and respects almost_full back-pressure.
- Checker side pops the N output FIFOs, verifies destination and per-(source,destination) ordering, and counts words per output.
- Replaces hand-sequenced stimulus with a start/done block usable in simulation and on-chip self-test.

Parameters:
- N_CH, 4, channel count; power of two, ≥2; LOG2N = $clog2(N_CH).
- DATA_W, 10, word width; must satisfy DATA_W ≥ 2*LOG2N+1.
- CNT_W, 8, width of words_per_pair.
- TIMEOUT, 255, DRAIN cycles without a pop before aborting.

Ports:
- clk  in  1  clock (all logic on rising edge).
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a test run.
- mode  in  1  0 = all-pairs, 1 = single destination.
- dest_sel  in  LOG2N  destination used when mode=1.
- words_per_pair  in  CNT_W  words per (source,destination) pair.
- almost_full  in  N_CH  input-FIFO almost-full flags.
- push  out  N_CH  push strobes to input FIFOs.
- data_in  out  N_CH*DATA_W  words to input FIFOs; channel s in slice s.
- empty  in  N_CH  output-FIFO empty flags.
- pop  out  N_CH  pop strobes to output FIFOs.
- data_out  in  N_CH*DATA_W  output-FIFO data, valid the cycle after pop.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE.
- error  out  1  sticky mismatch/timeout flag.
- err_cnt  out  8  saturating error count.
- rx_cnt  out  N_CH*(CNT_W+LOG2N)  words received per output.

Behaviour:
- Word format: {dest[LOG2N], src[LOG2N], seq[SEQ_W]} with SEQ_W = DATA_W-2*LOG2N; dest is at the MSBs.
- reset: state IDLE; every output 0; all internal counters 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start:
  - Latch mode, dest_sel and words_per_pair.
  - Clear error, err_cnt, rx_cnt and the seq/expected tables.
  - Go to RUN; if words_per_pair==0, go straight to DONE.
  - done drops the cycle after start.
- start is ignored in RUN and DRAIN.
- RUN, generator lane s:
  - Registered push[s]=1 with data_in[s]=word when !almost_full[s] and words remain.
  - almost_full sampled high → no push that cycle; never push while almost_full=1.
  - All-pairs order: dest 0..N_CH-1, words_per_pair each. Single mode: dest_sel only.
  - seq per (s,dest) starts at 0, increments per push and wraps modulo 2^SEQ_W.
- RUN → DRAIN: all lanes finished; all push=0 from that cycle.
- Checker (active in RUN and DRAIN):
  - pop[o]=1 whenever !empty[o]; data_out[o] is sampled the next cycle.
  - Check: dest field must equal o, and seq must equal expected[src][o] (modulo 2^SEQ_W).
  - Either mismatch → err_cnt+1 (saturates at 255) and error=1.
  - expected[src][o] advances to the received seq+1 on every received word, good or bad.
  - rx_cnt[o]+1 per received word.
- DRAIN → DONE:
  - Total received equals N_CH*N_CH*wpp (all-pairs) or N_CH*wpp (single).
  - Or timeout counter hits TIMEOUT with no pop → error=1, err_cnt+1.
  - Timeout counter resets on any pop.
- DONE: pop=0; error, err_cnt and rx_cnt held until the next start.
- Simultaneous pop on several outputs in one cycle: all are checked in parallel.
- reset mid-run: immediate return to IDLE with outputs cleared; no partial done.

Optional Feature:
- Macro GEN_CHK_RANDOM_EN.
- Defined: a 16-bit LFSR (seed 16'hACE1 at reset) gates pop[o] with LFSR bit o, and push[s] with bit s+N_CH, throttling traffic to exercise back-pressure.
- Undefined: pop and push are asserted whenever permitted; no LFSR logic exists.

Decomposition:
- Package gen_chk_pkg holds:
  - FSM state enum.
  - LOG2N/SEQ_W width functions.
  - pack_word/unpack fields functions.
  - Default TIMEOUT constant.
- Sub-module gen_chk_lane: one generator lane (dest iterator, seq table, push logic), instantiated N_CH times.
- Checker and FSM stay in the top module.

Test Plan:
- Defaults, mode=0, wpp=1, ideal switch model:
  - Each input receives 4 words with dest 0,1,2,3.
  - done after drain; rx_cnt={1,1,1,1}×4 = 4 each; err_cnt=0.
- mode=1, dest_sel=2, wpp=6:
  - 24 words all reach output 2; rx_cnt[2]=24, others 0; error=0.
- Hold almost_full[1]=1 for 20 cycles mid-RUN:
  - push[1] stays 0 throughout; run completes with err_cnt=0.
- Model swaps two consecutive words from src 3 on output 0:
  - err_cnt=2, error=1, done still reached.
- Model drops one word:
  - DRAIN times out after 255 idle cycles; error=1, err_cnt=1, done=1.
- Assert reset mid-RUN, then start again:
  - All outputs 0 during reset; second run passes cleanly.
  - With GEN_CHK_RANDOM_EN defined, the same wpp=1 run still ends with err_cnt=0.

Source files
------------

// File: rtl/gen_chk_pkg.sv
// Shared types and helpers for the gen_chk_trafico traffic generator/checker.
// Word layout is {dest, src, seq} with dest at the MSBs.
package gen_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Idle drain cycles tolerated before a run is declared stuck.
    localparam int TIMEOUT_DEF = 255;

    function automatic int calc_log2n(input int n);
        return $clog2(n);
    endfunction

    function automatic int calc_seq_w(input int data_w, input int n);
        return data_w - 2 * $clog2(n);
    endfunction

    // Fields are passed zero-extended to 32 bits; callers truncate the result to DATA_W.
    function automatic logic [31:0] pack_word(input int log2n, input int seq_w,
                                              input logic [31:0] dest,
                                              input logic [31:0] src,
                                              input logic [31:0] seq);
        logic [31:0] seq_mask;
        seq_mask = (32'd1 << seq_w) - 32'd1;
        return (dest << (log2n + seq_w)) | (src << seq_w) | (seq & seq_mask);
    endfunction

    function automatic logic [31:0] word_dest(input logic [31:0] w, input int log2n, input int seq_w);
        return (w >> (log2n + seq_w)) & ((32'd1 << log2n) - 32'd1);
    endfunction

    function automatic logic [31:0] word_src(input logic [31:0] w, input int log2n, input int seq_w);
        return (w >> seq_w) & ((32'd1 << log2n) - 32'd1);
    endfunction

    function automatic logic [31:0] word_seq(input logic [31:0] w, input int seq_w);
        return w & ((32'd1 << seq_w) - 32'd1);
    endfunction

endpackage

// File: rtl/gen_chk_trafico_lane.sv
// One generator lane: walks the destination list, keeps a sequence number per
// destination and emits registered push strobes honouring almost_full.
module gen_chk_lane
    import gen_chk_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = 10,
    parameter int CNT_W  = 8,
    parameter int SRC    = 0
)(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic                          run,
    input  logic                          mode,
    input  logic [calc_log2n(N_CH)-1:0]   dest_sel,
    input  logic [CNT_W-1:0]              wpp,
    input  logic                          almost_full,
    input  logic                          gate,
    output logic                          push,
    output logic [DATA_W-1:0]             data_in,
    output logic                          finished
);
    localparam int LOG2N = calc_log2n(N_CH);
    localparam int SEQ_W = calc_seq_w(DATA_W, N_CH);

    logic [LOG2N-1:0] dest_reg;
    logic [LOG2N-1:0] dest_cur;
    logic [CNT_W-1:0] cnt_reg;
    logic [SEQ_W-1:0] seq_reg [N_CH];
    logic             fin_reg;
    logic             fire;
    logic             last_word;

    // Single mode pins the destination; all-pairs walks dest_reg upward.
    assign dest_cur  = mode ? dest_sel : dest_reg;
    assign fire      = run && !fin_reg && !almost_full && gate;
    assign last_word = (cnt_reg == wpp - 1'b1);
    assign finished  = fin_reg;

    // Push register, destination iterator and per-destination sequence table.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            push     <= 1'b0;
            data_in  <= '0;
            dest_reg <= '0;
            cnt_reg  <= '0;
            fin_reg  <= 1'b0;
            for (int i = 0; i < N_CH; i++) seq_reg[i] <= '0;
        end else if (load) begin
            push     <= 1'b0;
            dest_reg <= '0;
            cnt_reg  <= '0;
            fin_reg  <= 1'b0;
            for (int i = 0; i < N_CH; i++) seq_reg[i] <= '0;
        end else begin
            push <= fire;
            if (fire) begin
                data_in <= DATA_W'(pack_word(LOG2N, SEQ_W, 32'(dest_cur), 32'(SRC),
                                             32'(seq_reg[dest_cur])));
                seq_reg[dest_cur] <= seq_reg[dest_cur] + 1'b1;
                if (last_word) begin
                    cnt_reg <= '0;
                    if (mode || dest_reg == LOG2N'(N_CH - 1)) fin_reg <= 1'b1;
                    else dest_reg <= dest_reg + 1'b1;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/gen_chk_trafico.sv
// Traffic generator/checker for the N-channel FIFO/arbiter switch.
// Build option: define GEN_CHK_RANDOM_EN to throttle push/pop with a 16-bit LFSR.
module gen_chk_trafico
    import gen_chk_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int DATA_W  = 10,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = TIMEOUT_DEF
)(
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic                                    mode,
    input  logic [calc_log2n(N_CH)-1:0]             dest_sel,
    input  logic [CNT_W-1:0]                        words_per_pair,
    input  logic [N_CH-1:0]                         almost_full,
    output logic [N_CH-1:0]                         push,
    output logic [N_CH*DATA_W-1:0]                  data_in,
    input  logic [N_CH-1:0]                         empty,
    output logic [N_CH-1:0]                         pop,
    input  logic [N_CH*DATA_W-1:0]                  data_out,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    error,
    output logic [7:0]                              err_cnt,
    output logic [N_CH*(CNT_W+calc_log2n(N_CH))-1:0] rx_cnt
);
    localparam int LOG2N = calc_log2n(N_CH);
    localparam int SEQ_W = calc_seq_w(DATA_W, N_CH);
    localparam int RX_W  = CNT_W + LOG2N;
    localparam int TOT_W = CNT_W + 2 * LOG2N;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    state_t            state_reg, state_next;
    logic              mode_reg;
    logic [LOG2N-1:0]  dest_sel_reg;
    logic [CNT_W-1:0]  wpp_reg;
    logic              load;
    logic              run;
    logic              active;
    logic              to_hit;
    logic [N_CH-1:0]   lane_fin;
    logic [N_CH-1:0]   push_gate;
    logic [N_CH-1:0]   pop_gate;
    logic [N_CH-1:0]   hit;
    logic [N_CH-1:0]   got;
    logic [TOT_W-1:0]  total_reg, target, got_cnt;
    logic [TO_W-1:0]   to_reg;
    logic [7:0]        err_cnt_reg, err_next, hit_cnt;
    logic [8:0]        err_sum;
    logic              error_reg;

    assign run    = (state_reg == ST_RUN);
    assign active = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    assign busy   = active;
    assign done   = (state_reg == ST_DONE);
    assign error  = error_reg;
    assign err_cnt = err_cnt_reg;
    assign target = mode_reg ? (TOT_W'(wpp_reg) << LOG2N) : (TOT_W'(wpp_reg) << (2 * LOG2N));

`ifdef GEN_CHK_RANDOM_EN
    logic [15:0] lfsr_reg;

    // Free-running maximal-length LFSR used only to throttle strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_reg <= 16'hACE1;
        else       lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    end

    assign pop_gate  = lfsr_reg[N_CH-1:0];
    assign push_gate = lfsr_reg[2*N_CH-1:N_CH];
`else
    assign pop_gate  = '1;
    assign push_gate = '1;
`endif

    // Next-state logic; a start with zero words completes immediately.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        to_hit     = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = (words_per_pair == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (&lane_fin) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (total_reg == target) begin
                    state_next = ST_DONE;
                end else if (to_reg == TO_W'(TIMEOUT) && !(|pop)) begin
                    to_hit     = 1'b1;
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Per-cycle tallies of received words and detected errors.
    always_comb begin
        hit_cnt = '0;
        got_cnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            hit_cnt = hit_cnt + 8'(hit[i]);
            got_cnt = got_cnt + TOT_W'(got[i]);
        end
        hit_cnt  = hit_cnt + 8'(to_hit);
        err_sum  = {1'b0, err_cnt_reg} + {1'b0, hit_cnt};
        err_next = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    // State register and run configuration captured at start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            mode_reg     <= 1'b0;
            dest_sel_reg <= '0;
            wpp_reg      <= '0;
        end else begin
            state_reg <= state_next;
            if (load) begin
                mode_reg     <= mode;
                dest_sel_reg <= dest_sel;
                wpp_reg      <= words_per_pair;
            end
        end
    end

    // Sticky error, saturating error count, received total and drain watchdog.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error_reg   <= 1'b0;
            err_cnt_reg <= '0;
            total_reg   <= '0;
            to_reg      <= '0;
        end else if (load) begin
            error_reg   <= 1'b0;
            err_cnt_reg <= '0;
            total_reg   <= '0;
            to_reg      <= '0;
        end else begin
            err_cnt_reg <= err_next;
            if ((|hit) || to_hit) error_reg <= 1'b1;
            total_reg <= total_reg + got_cnt;
            if (state_reg == ST_DRAIN && !(|pop)) to_reg <= to_reg + 1'b1;
            else                                  to_reg <= '0;
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_lane
        gen_chk_lane #(
            .N_CH   (N_CH),
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W),
            .SRC    (gi)
        ) u_lane (
            .clk         (clk),
            .reset       (reset),
            .load        (load),
            .run         (run),
            .mode        (mode_reg),
            .dest_sel    (dest_sel_reg),
            .wpp         (wpp_reg),
            .almost_full (almost_full[gi]),
            .gate        (push_gate[gi]),
            .push        (push[gi]),
            .data_in     (data_in[gi*DATA_W +: DATA_W]),
            .finished    (lane_fin[gi])
        );
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chk
        logic              rd_reg;
        logic [RX_W-1:0]   rx_reg;
        logic [SEQ_W-1:0]  exp_reg [N_CH];
        logic [DATA_W-1:0] word;
        logic [LOG2N-1:0]  w_dest;
        logic [LOG2N-1:0]  w_src;
        logic [SEQ_W-1:0]  w_seq;

        assign word   = data_out[gi*DATA_W +: DATA_W];
        assign w_dest = LOG2N'(word_dest(32'(word), LOG2N, SEQ_W));
        assign w_src  = LOG2N'(word_src(32'(word), LOG2N, SEQ_W));
        assign w_seq  = SEQ_W'(word_seq(32'(word), SEQ_W));

        assign pop[gi] = active && !empty[gi] && pop_gate[gi];
        assign got[gi] = rd_reg;
        assign hit[gi] = rd_reg && ((w_dest != LOG2N'(gi)) || (w_seq != exp_reg[w_src]));
        assign rx_cnt[gi*RX_W +: RX_W] = rx_reg;

        // Word popped last cycle is checked now; expectation follows what arrived.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rd_reg <= 1'b0;
                rx_reg <= '0;
                for (int i = 0; i < N_CH; i++) exp_reg[i] <= '0;
            end else if (load) begin
                rd_reg <= 1'b0;
                rx_reg <= '0;
                for (int i = 0; i < N_CH; i++) exp_reg[i] <= '0;
            end else begin
                rd_reg <= pop[gi];
                if (rd_reg) begin
                    exp_reg[w_src] <= w_seq + 1'b1;
                    rx_reg         <= rx_reg + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gen_chk_trafico.sv
// Self-checking bench for gen_chk_trafico with an ideal switch model and
// injectable faults (reorder / drop).
module tb_gen_chk_trafico;
    localparam int N_CH   = 4;
    localparam int DATA_W = 10;
    localparam int CNT_W  = 8;
    localparam int LOG2N  = 2;
    localparam int SEQ_W  = DATA_W - 2 * LOG2N;
    localparam int RX_W   = CNT_W + LOG2N;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        start;
    logic                        mode;
    logic [LOG2N-1:0]            dest_sel;
    logic [CNT_W-1:0]            words_per_pair;
    logic [N_CH-1:0]             almost_full;
    logic [N_CH-1:0]             push;
    logic [N_CH*DATA_W-1:0]      data_in;
    logic [N_CH-1:0]             empty;
    logic [N_CH-1:0]             pop;
    logic [N_CH*DATA_W-1:0]      data_out;
    logic                        busy, done, error;
    logic [7:0]                  err_cnt;
    logic [N_CH*RX_W-1:0]        rx_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state
    logic [DATA_W-1:0] oq [N_CH][$];
    int  cfg_mode, cfg_dest, cfg_wpp;
    int  fault;
    bit  hold_v, dropped;
    logic [DATA_W-1:0] held_w;
    int  pushes_seen [N_CH];
    logic [N_CH-1:0] af_prev;

    always #5 clk = ~clk;

    gen_chk_trafico dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .mode           (mode),
        .dest_sel       (dest_sel),
        .words_per_pair (words_per_pair),
        .almost_full    (almost_full),
        .push           (push),
        .data_in        (data_in),
        .empty          (empty),
        .pop            (pop),
        .data_out       (data_out),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .err_cnt        (err_cnt),
        .rx_cnt         (rx_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // k-th word lane s should emit, straight from the traffic rules.
    function automatic logic [DATA_W-1:0] exp_word(input int s, input int k);
        int d, q;
        d = cfg_mode ? cfg_dest : k / cfg_wpp;
        q = (cfg_mode ? k : k % cfg_wpp) % (1 << SEQ_W);
        return DATA_W'(d * (1 << (LOG2N + SEQ_W)) + s * (1 << SEQ_W) + q);
    endfunction

    function automatic int lane_total();
        return cfg_mode ? cfg_wpp : N_CH * cfg_wpp;
    endfunction

    // Ideal switch: pushed words go straight to the output queue named by dest.
    task automatic route(input logic [DATA_W-1:0] w);
        int wi, src, dst, sq;
        wi  = int'(w);
        src = (wi >> SEQ_W) % N_CH;
        dst = wi >> (SEQ_W + LOG2N);
        sq  = wi % (1 << SEQ_W);
        if (fault == 1 && src == 3 && dst == 0 && sq == 0 && !hold_v) begin
            held_w = w;
            hold_v = 1'b1;
        end else if (fault == 1 && src == 3 && dst == 0 && sq == 1 && hold_v) begin
            oq[dst].push_back(w);
            oq[dst].push_back(held_w);
        end else if (fault == 2 && src == 0 && dst == 0 && !dropped) begin
            dropped = 1'b1;
        end else begin
            oq[dst].push_back(w);
        end
    endtask

    always @(posedge clk) begin : model
        logic [N_CH-1:0]        p, pp, af_now;
        logic [N_CH*DATA_W-1:0] d;
        logic [DATA_W-1:0]      w;
        p = push; pp = pop; d = data_in; af_now = almost_full;
        #1;
        if (reset) begin
            for (int o = 0; o < N_CH; o++) oq[o].delete();
        end else begin
            for (int s = 0; s < N_CH; s++) begin
                if (p[s]) begin
                    w = d[s*DATA_W +: DATA_W];
                    chk("push_af", 32'(af_prev[s]), 0);
                    chk("push_in_budget", 32'(pushes_seen[s] < lane_total()), 1);
                    chk("push_word", 32'(w), 32'(exp_word(s, pushes_seen[s])));
                    pushes_seen[s]++;
                    route(w);
                end
            end
            for (int o = 0; o < N_CH; o++) begin
                if (pp[o]) begin
                    chk("pop_nonempty", 32'(oq[o].size() > 0), 1);
                    if (oq[o].size() > 0) data_out[o*DATA_W +: DATA_W] = oq[o].pop_front();
                end
            end
        end
        af_prev = af_now;
        for (int o = 0; o < N_CH; o++) empty[o] = (oq[o].size() == 0);
    end

    task automatic run_test(input string name, input int m, input int ds, input int wpp,
                            input int flt, input bit rnd_af, input bit af_hold, input int exp_err);
        int cyc, exp_rx;
        cfg_mode = m; cfg_dest = ds; cfg_wpp = wpp;
        fault = flt; hold_v = 1'b0; dropped = 1'b0;
        for (int s = 0; s < N_CH; s++) pushes_seen[s] = 0;
        @(negedge clk);
        mode = m[0]; dest_sel = LOG2N'(ds); words_per_pair = CNT_W'(wpp); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({name, ":busy_after_start"}, 32'(busy), 32'(wpp != 0));
        chk({name, ":done_after_start"}, 32'(done), 32'(wpp == 0));
        if (af_hold) begin
            repeat (2) @(negedge clk);
            almost_full[1] = 1'b1;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                chk({name, ":push1_held"}, 32'(push[1]), 0);
            end
            almost_full[1] = 1'b0;
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            if (rnd_af) almost_full = N_CH'($urandom) & N_CH'($urandom);
        end
        almost_full = '0;
        chk({name, ":done"}, 32'(done), 1);
        chk({name, ":busy_end"}, 32'(busy), 0);
        for (int o = 0; o < N_CH; o++) begin
            exp_rx = m ? ((o == ds) ? N_CH * wpp : 0) : N_CH * wpp;
            if (flt == 2 && o == 0) exp_rx--;
            chk({name, ":rx_cnt"}, 32'(rx_cnt[o*RX_W +: RX_W]), 32'(exp_rx));
        end
        chk({name, ":err_cnt"}, 32'(err_cnt), 32'(exp_err));
        chk({name, ":error"}, 32'(error), 32'(exp_err != 0));
        for (int s = 0; s < N_CH; s++)
            chk({name, ":lane_pushes"}, 32'(pushes_seen[s]), 32'(lane_total()));
        $display("run %-16s mode=%0d dest=%0d wpp=%0d cycles=%0d err_cnt=%0d", name, m, ds, wpp, cyc, err_cnt);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0; dest_sel = '0; words_per_pair = '0;
        almost_full = '0; empty = '1; data_out = '0; fault = 0; af_prev = '0;
        cfg_mode = 0; cfg_dest = 0; cfg_wpp = 1;
        for (int s = 0; s < N_CH; s++) pushes_seen[s] = 0;
        repeat (3) @(negedge clk);
        chk("rst_push", 32'(push), 0);
        chk("rst_pop", 32'(pop), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        chk("rst_rx_cnt", 32'(rx_cnt), 0);
        reset = 1'b0;
        @(negedge clk);

        run_test("allpairs_wpp1", 0, 0, 1, 0, 1'b0, 1'b0, 0);
        run_test("single_d2_wpp6", 1, 2, 6, 0, 1'b0, 1'b0, 0);
        run_test("af_hold_lane1", 0, 0, 8, 0, 1'b0, 1'b1, 0);
        run_test("swap_src3_out0", 0, 0, 2, 1, 1'b0, 1'b0, 2);
        run_test("drop_one", 0, 0, 1, 2, 1'b0, 1'b0, 1);

        // Reset in the middle of a run
        cfg_mode = 0; cfg_dest = 0; cfg_wpp = 5; fault = 0;
        for (int s = 0; s < N_CH; s++) pushes_seen[s] = 0;
        @(negedge clk);
        mode = 1'b0; words_per_pair = 8'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_push", 32'(push), 0);
        chk("midrst_pop", 32'(pop), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_err_cnt", 32'(err_cnt), 0);
        chk("midrst_rx_cnt", 32'(rx_cnt), 0);
        $display("run %-16s reset asserted mid-run", "mid_reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_test("after_reset", 0, 0, 1, 0, 1'b0, 1'b0, 0);
        run_test("wpp_zero", 0, 0, 0, 0, 1'b0, 1'b0, 0);
        run_test("seq_wrap", 1, 2, 70, 0, 1'b0, 1'b0, 0);
        for (int r = 0; r < 6; r++)
            run_test("random", int'($urandom_range(0, 1)), int'($urandom_range(0, N_CH - 1)),
                     int'($urandom_range(1, 20)), 0, 1'b1, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
